dmem_controller: RTL and testbench



---
 rtl/dmem_pkg.sv | 10 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_controller.sv | 140 ++++++++++++++
 tb/tb_dmem_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default parameters for the data-memory controller.
package dmem_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY, ST_RESP} state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DEPTH     = 256;
  localparam int DEF_LATENCY   = 2;
  localparam int DEF_MON_WORDS = 4;
endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a parallel tap of the low words.
module dmem_array #(
  parameter int DATA_W    = 16,
  parameter int AW        = 8,
  parameter int DEPTH     = 256,
  parameter int MON_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic                        we,
  input  logic [AW-1:0]               addr,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata,
  output logic [MON_WORDS*DATA_W-1:0] tap
);
  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only moves on a read so the response word survives idle cycles
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

  for (genvar g = 0; g < MON_WORDS; g++) begin : g_tap
    assign tap[(MON_WORDS-1-g)*DATA_W +: DATA_W] = mem[g];
  end
endmodule

// File: rtl/dmem_controller.sv
// Valid/ready front end for the word RAM: self-init, fixed-latency single
// outstanding access, and a registered snapshot of the low words.
module dmem_controller
  import dmem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int MON_WORDS = DEF_MON_WORDS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        init_done,
  output logic [MON_WORDS*DATA_W-1:0] monitor
);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t              state, state_nxt;
  logic [AW-1:0]       icnt;
  logic [WCW-1:0]      wcnt, wcnt_nxt;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                rsp_zero;

  logic                acc, acc_write, acc_err, in_init;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                ram_en, ram_we;
  logic [AW-1:0]       ram_addr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;
  logic [MON_WORDS*DATA_W-1:0] tap;

  // acc marks the edge that enters RESP; with LATENCY 1 that is the accept edge
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    acc       = 1'b0;
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      ST_INIT: if (icnt == AW'(DEPTH-1)) state_nxt = ST_IDLE;
      ST_IDLE: begin
        req_ready = 1'b1;
        acc_write = req_write;
        acc_addr  = req_addr;
        acc_wdata = req_wdata;
        if (req_valid) begin
          if (LATENCY > 1) begin
            state_nxt = ST_BUSY;
            wcnt_nxt  = WCW'(LATENCY-2);
          end else begin
            state_nxt = ST_RESP;
            acc       = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (wcnt == '0) begin
          state_nxt = ST_RESP;
          acc       = 1'b1;
        end else begin
          wcnt_nxt = wcnt - 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign acc_err   = 32'(acc_addr) >= DEPTH;
  assign in_init   = (state == ST_INIT);
  assign ram_en    = in_init | (acc & ~acc_err);
  assign ram_we    = in_init | acc_write;
  assign ram_addr  = in_init ? icnt : acc_addr[AW-1:0];
  assign ram_wdata = in_init ? DATA_W'(icnt) : acc_wdata;
  assign rsp_rdata = rsp_zero ? '0 : ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      icnt      <= '0;
      wcnt      <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_err   <= 1'b0;
      rsp_zero  <= 1'b1;
      init_done <= 1'b0;
      monitor   <= '0;
    end else begin
      state   <= state_nxt;
      wcnt    <= wcnt_nxt;
      monitor <= tap;
      if (in_init) begin
        icnt <= icnt + 1'b1;
        if (icnt == AW'(DEPTH-1)) init_done <= 1'b1;
      end
      if (req_ready && req_valid) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      // stores and out-of-range accesses report zero data
      if (acc) begin
        rsp_err  <= acc_err;
        rsp_zero <= acc_write | acc_err;
      end
    end
  end

  dmem_array #(
    .DATA_W(DATA_W), .AW(AW), .DEPTH(DEPTH), .MON_WORDS(MON_WORDS)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata),
    .tap  (tap)
  );
endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench: three controller instances (default, DEPTH 200 / LATENCY 1,
// DEPTH 16 / LATENCY 4) sharing clock and reset.
module tb_dmem_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0]       req_valid, req_write, rsp_ready;
  logic [2:0]       req_ready, rsp_valid, rsp_err, init_done;
  logic [2:0][7:0]  req_addr;
  logic [2:0][15:0] req_wdata, rsp_rdata;
  logic [2:0][63:0] monitor;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_controller u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .init_done(init_done[0]), .monitor(monitor[0]));

  dmem_controller #(.DEPTH(200), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .init_done(init_done[1]), .monitor(monitor[1]));

  dmem_controller #(.DEPTH(16), .LATENCY(4)) u2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .init_done(init_done[2]), .monitor(monitor[2]));

  typedef struct {
    int          d;
    logic        w;
    logic [7:0]  a;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req_ready"}, 64'(req_ready[0]), 64'd0);
    chk({tag, " rsp_valid"}, 64'(rsp_valid[0]), 64'd0);
    chk({tag, " rsp_rdata"}, 64'(rsp_rdata[0]), 64'd0);
    chk({tag, " rsp_err"},   64'(rsp_err[0]),   64'd0);
    chk({tag, " init_done"}, 64'(init_done[0]), 64'd0);
    chk({tag, " monitor"},   monitor[0],        64'd0);
  endtask

  // Call at a negedge with the instance idle; returns data, error and the
  // number of rising edges from request drive to rsp_valid.
  task automatic txn(input int d, input logic w, input logic [7:0] a, input logic [15:0] wd,
                     output logic [15:0] rd, output logic er, output int n);
    rsp_ready[d] = 1'b1;
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    @(posedge clk); n = 1; @(negedge clk);
    req_valid[d] = 1'b0;
    while (!rsp_valid[d] && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_init(input int d, output int n);
    n = 0;
    while (!init_done[d] && n < 400) begin
      @(posedge clk); n++; @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          n;

    vecs[0]  = '{0, 1'b0, 8'd200, 16'h0000, 16'd200,  1'b0, 2};
    vecs[1]  = '{0, 1'b1, 8'd2,   16'hBEEF, 16'h0000, 1'b0, 2};
    vecs[2]  = '{0, 1'b0, 8'd2,   16'h0000, 16'hBEEF, 1'b0, 2};
    vecs[3]  = '{0, 1'b0, 8'd255, 16'h0000, 16'd255,  1'b0, 2};
    vecs[4]  = '{1, 1'b1, 8'd250, 16'h5555, 16'h0000, 1'b1, 1};
    vecs[5]  = '{1, 1'b0, 8'd250, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[6]  = '{1, 1'b0, 8'd199, 16'h0000, 16'd199,  1'b0, 1};
    vecs[7]  = '{1, 1'b0, 8'd0,   16'h0000, 16'd0,    1'b0, 1};
    vecs[8]  = '{2, 1'b1, 8'd15,  16'hA5A5, 16'h0000, 1'b0, 4};
    vecs[9]  = '{2, 1'b0, 8'd15,  16'h0000, 16'hA5A5, 1'b0, 4};
    vecs[10] = '{2, 1'b0, 8'd16,  16'h0000, 16'h0000, 1'b1, 4};
    vecs[11] = '{2, 1'b0, 8'd3,   16'h0000, 16'd3,    1'b0, 4};

    req_valid = '0; req_write = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0;

    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    wait_init(0, n);
    chk("init cycles", 64'(n), 64'd256);
    chk("init req_ready", 64'(req_ready[0]), 64'd1);
    chk("init monitor", monitor[0], 64'h0000_0001_0002_0003);
    chk("init others", 64'(init_done[2:1]), 64'd3);

    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, rd, er, n);
      chk($sformatf("vec%0d rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      chk($sformatf("vec%0d err", i),   64'(er), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d latency", i), 64'(n), 64'(vecs[i].exp_lat));
    end
    chk("monitor store", monitor[0], 64'h0000_0001_BEEF_0003);
    chk("monitor oob store", monitor[1], 64'h0000_0001_0002_0003);
    chk("monitor d16", monitor[2], 64'h0000_0001_0002_0003);

    // response back-pressure with a new request pending
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'd7;
    @(posedge clk); @(negedge clk);
    req_valid[0] = 1'b0;
    n = 1;
    while (!rsp_valid[0] && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
    chk("stall first valid", 64'(rsp_valid[0]), 64'd1);
    req_valid[0] = 1'b1; req_addr[0] = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("stall%0d rsp_valid", i), 64'(rsp_valid[0]), 64'd1);
      chk($sformatf("stall%0d rsp_rdata", i), 64'(rsp_rdata[0]), 64'd7);
      chk($sformatf("stall%0d rsp_err", i),   64'(rsp_err[0]),   64'd0);
      chk($sformatf("stall%0d req_ready", i), 64'(req_ready[0]), 64'd0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post hs rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("post hs req_ready", 64'(req_ready[0]), 64'd1);
    chk("post hs rdata kept", 64'(rsp_rdata[0]), 64'd7);
    @(posedge clk); @(negedge clk);
    req_valid[0] = 1'b0;
    chk("pending accepted", 64'(req_ready[0]), 64'd0);
    chk("busy rdata kept", 64'(rsp_rdata[0]), 64'd7);
    @(posedge clk); @(negedge clk);
    chk("pending rsp_valid", 64'(rsp_valid[0]), 64'd1);
    chk("pending rdata", 64'(rsp_rdata[0]), 64'd9);
    @(posedge clk); @(negedge clk);

    // LATENCY 1 back-to-back: one response every two cycles
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'd5;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("b2b%0d rsp_valid", i), 64'(rsp_valid[1]), 64'((i % 2) == 0));
      if (rsp_valid[1]) chk($sformatf("b2b%0d rdata", i), 64'(rsp_rdata[1]), 64'd5);
    end
    req_valid[1] = 1'b0;
    @(posedge clk); @(negedge clk);

    // reset in the middle of a store's wait
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'd0; req_wdata[0] = 16'h1234;
    @(posedge clk); @(negedge clk);
    req_valid[0] = 1'b0;
    chk("mid busy rsp_valid", 64'(rsp_valid[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    wait_init(0, n);
    chk("reinit cycles", 64'(n), 64'd256);
    chk("reinit monitor", monitor[0], 64'h0000_0001_0002_0003);
    txn(0, 1'b0, 8'd0, 16'h0000, rd, er, n);
    chk("reinit word0", 64'(rd), 64'd0);
    chk("reinit err", 64'(er), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
